// File: rtl/uart_rx.sv
// 8N1 UART receiver with a single-entry valid/ready holding register.
// Samples each bit at mid-period and flags framing errors and overruns.
module uart_rx #(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    input  logic       ready_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int BIT_PERIOD  = CLK_FREQ / BAUD_RATE;
    localparam int HALF_PERIOD = BIT_PERIOD / 2;

    localparam logic [15:0] BIT_LAST  = 16'(BIT_PERIOD - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t      state;
    logic        rx_m;
    logic        rx_s;
    logic [15:0] clk_cnt;
    logic [3:0]  bit_cnt;
    logic [7:0]  shift;

    // Two-flop synchroniser; idles high so reset looks like an idle line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx_i;
            rx_s <= rx_m;
        end
    end

    // Receive FSM, holding register and flag pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
            if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state   <= START;
                        clk_cnt <= '0;
                        busy_o  <= 1'b1;
                    end
                end
                START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        shift   <= {rx_s, shift[7:1]};
                        clk_cnt <= '0;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        if (rx_s) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                            // A pop on this same cycle frees the slot
                            if (!valid_o || ready_i) begin
                                data_o  <= shift;
                                valid_o <= 1'b1;
                            end else begin
                                overrun_o <= 1'b1;
                            end
                        end else begin
                            frame_err_o <= 1'b1;
                            state       <= BREAK;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                BREAK: begin
                    // Held-low line must go high before a new start counts
                    if (rx_s) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
